// File: rtl/data_frame_transmitter_pkg.sv
// Shared data-link definitions for the frame transmitter and the host-side receiver:
// sync byte defaults, one-hot frame state encoding and the byte-issue handshake phases.
package data_frame_transmitter_pkg;

   localparam logic [7:0] HDR0_DEFAULT = 8'hAB;
   localparam logic [7:0] HDR1_DEFAULT = 8'h41;

   typedef enum logic [5:0] {
      ST_IDLE    = 6'b000001,
      ST_HDR0    = 6'b000010,
      ST_HDR1    = 6'b000100,
      ST_PAYLOAD = 6'b001000,
      ST_CKSUM   = 6'b010000,
      ST_DONE    = 6'b100000
   } frame_state_e;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'd0,
      PH_ISSUE = 2'd1,
      PH_WAIT  = 2'd2
   } issue_phase_e;

   // Running payload checksum is a plain mod-256 byte sum.
   function automatic logic [7:0] cksum_add(input logic [7:0] sum, input logic [7:0] data);
      return sum + data;
   endfunction

endpackage

// File: rtl/data_frame_transmitter_if.sv
// Host/UART-facing signals of the frame transmitter. The master modport is the
// transmitter's view; the slave modport is the host/UART-engine side.
interface data_frame_transmitter_if #(
   parameter int BYTES = 3136
);
   logic                 i_send_start;
   logic [BYTES*8-1:0]   i_send_data;
   logic [7:0]           o_tx_byte;
   logic                 o_tx_start;
   logic                 i_tx_done;
   logic                 o_busy;
   logic                 o_send_done;

   modport master (
      input  i_send_start,
      input  i_send_data,
      input  i_tx_done,
      output o_tx_byte,
      output o_tx_start,
      output o_busy,
      output o_send_done
   );

   modport slave (
      output i_send_start,
      output i_send_data,
      output i_tx_done,
      input  o_tx_byte,
      input  o_tx_start,
      input  o_busy,
      input  o_send_done
   );
endinterface

// File: rtl/data_frame_transmitter_tx_byte_issue.sv
// Single-byte handshake toward the UART TX engine: a request loads the byte and
// raises tx_start for one cycle, then the byte is held until the engine's done pulse.
//
//  phase    | meaning
//  PH_IDLE  | no byte outstanding
//  PH_ISSUE | tx_start high this cycle; engine done ignored
//  PH_WAIT  | byte held, waiting for engine done
module tx_byte_issue
   import data_frame_transmitter_pkg::*;
(
   input  logic       i_clk_sys,
   input  logic       i_rst,
   input  logic       req,
   input  logic [7:0] byte_in,
   input  logic       tx_done,
   output logic [7:0] tx_byte,
   output logic       tx_start,
   output logic       byte_done
);

   issue_phase_e phase;
   issue_phase_e phase_nxt;

   // Phase register plus the registered byte/start outputs toward the engine.
   always_ff @(posedge i_clk_sys) begin
      if (i_rst) begin
         phase    <= PH_IDLE;
         tx_byte  <= 8'h00;
         tx_start <= 1'b0;
      end else begin
         phase    <= phase_nxt;
         tx_start <= req;
         if (req) begin
            tx_byte <= byte_in;
         end
      end
   end

   // Next phase; a new request may arrive in the same cycle the previous byte completes.
   always_comb begin
      phase_nxt = phase;
      byte_done = 1'b0;
      case (phase)
         PH_IDLE:  phase_nxt = PH_IDLE;
         PH_ISSUE: phase_nxt = PH_WAIT;
         PH_WAIT: begin
            if (tx_done) begin
               byte_done = 1'b1;
               phase_nxt = PH_IDLE;
            end
         end
         default:  phase_nxt = PH_IDLE;
      endcase
      if (req) begin
         phase_nxt = PH_ISSUE;
      end
   end

endmodule

// File: rtl/data_frame_transmitter.sv
// Frames a wide result vector into a UART byte stream: HDR0, HDR1, then BYTES payload
// bytes MSB-first, optionally followed by a mod-256 payload checksum byte.
// Build option: DATA_TX_CHECKSUM_EN adds the checksum trailer state and accumulator.
//
//  state      | meaning
//  ST_IDLE    | waiting for a send request
//  ST_HDR0    | first sync byte in flight
//  ST_HDR1    | second sync byte in flight
//  ST_PAYLOAD | payload bytes in flight, cnt = bytes completed
//  ST_CKSUM   | checksum trailer in flight (checksum build only)
//  ST_DONE    | one-cycle completion pulse, busy already low
module data_frame_transmitter
   import data_frame_transmitter_pkg::*;
#(
   parameter int         BYTES = 3136,
   parameter logic [7:0] HDR0  = HDR0_DEFAULT,
   parameter logic [7:0] HDR1  = HDR1_DEFAULT
) (
   input  logic                     i_clk_sys,
   input  logic                     i_rst,
   data_frame_transmitter_if.master bus
);

   localparam int CNT_W = $clog2(BYTES + 1);
   localparam int W     = BYTES * 8;

   frame_state_e     state;
   frame_state_e     state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     shreg;
   logic             start_acc;
   logic             shift_en;
   logic             last_byte;
   logic             issue_req;
   logic [7:0]       issue_byte;
   logic             byte_done;
   logic [7:0]       tx_byte;
   logic             tx_start;
`ifdef DATA_TX_CHECKSUM_EN
   logic [7:0]       cksum;
   logic             payload_issue;
`endif

   assign start_acc = (state == ST_IDLE) && bus.i_send_start;
   assign last_byte = (cnt == CNT_W'(BYTES - 1));

   tx_byte_issue u_issue (
      .i_clk_sys (i_clk_sys),
      .i_rst     (i_rst),
      .req       (issue_req),
      .byte_in   (issue_byte),
      .tx_done   (bus.i_tx_done),
      .tx_byte   (tx_byte),
      .tx_start  (tx_start),
      .byte_done (byte_done)
   );

   // Frame state, payload shift register and byte counter.
   always_ff @(posedge i_clk_sys) begin
      if (i_rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         shreg <= '0;
      end else begin
         state <= state_nxt;
         if (start_acc) begin
            shreg <= bus.i_send_data;
            cnt   <= '0;
         end else if (shift_en) begin
            shreg <= {shreg[W-9:0], 8'h00};
            cnt   <= cnt + 1'b1;
         end
      end
   end

`ifdef DATA_TX_CHECKSUM_EN
   // Checksum covers every payload byte at the moment it is handed to the engine.
   always_ff @(posedge i_clk_sys) begin
      if (i_rst) begin
         cksum <= 8'h00;
      end else if (start_acc) begin
         cksum <= 8'h00;
      end else if (payload_issue) begin
         cksum <= cksum_add(cksum, issue_byte);
      end
   end
`endif

   // Next state and the byte to issue; each byte is requested as the previous one completes.
   always_comb begin
      state_nxt  = state;
      issue_req  = 1'b0;
      issue_byte = HDR0;
      shift_en   = 1'b0;
`ifdef DATA_TX_CHECKSUM_EN
      payload_issue = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (bus.i_send_start) begin
               state_nxt  = ST_HDR0;
               issue_req  = 1'b1;
               issue_byte = HDR0;
            end
         end
         ST_HDR0: begin
            if (byte_done) begin
               state_nxt  = ST_HDR1;
               issue_req  = 1'b1;
               issue_byte = HDR1;
            end
         end
         ST_HDR1: begin
            if (byte_done) begin
               state_nxt  = ST_PAYLOAD;
               issue_req  = 1'b1;
               issue_byte = shreg[W-1 -: 8];
`ifdef DATA_TX_CHECKSUM_EN
               payload_issue = 1'b1;
`endif
            end
         end
         ST_PAYLOAD: begin
            if (byte_done) begin
               shift_en = 1'b1;
               if (last_byte) begin
`ifdef DATA_TX_CHECKSUM_EN
                  state_nxt  = ST_CKSUM;
                  issue_req  = 1'b1;
                  issue_byte = cksum;
`else
                  state_nxt  = ST_DONE;
`endif
               end else begin
                  issue_req  = 1'b1;
                  issue_byte = shreg[W-9 -: 8];
`ifdef DATA_TX_CHECKSUM_EN
                  payload_issue = 1'b1;
`endif
               end
            end
         end
         ST_CKSUM: begin
            if (byte_done) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign bus.o_tx_byte   = tx_byte;
   assign bus.o_tx_start  = tx_start;
   assign bus.o_busy      = (state != ST_IDLE) && (state != ST_DONE);
   assign bus.o_send_done = (state == ST_DONE);

endmodule
